// File: rtl/serial_rx_fifo.sv
// Serial frame receiver (start, DATA_W data LSB-first, parity, stop) feeding a show-ahead FIFO.
// Optional frame timeout enabled by defining SERIAL_RX_TIMEOUT_EN.
module serial_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARITY_ODD  = 1,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             SCLK,
  input  logic                             SDATA,
  input  logic                             RD_EN,
  output logic [DATA_W-1:0]                CODE,
  output logic                             VALID,
  output logic                             FULL,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  COUNT,
  output logic                             PARITY_ERR,
  output logic                             FRAME_ERR,
  output logic                             OVERFLOW
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic          PAR_SENSE = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, state_n;

  logic sclk_s1, sclk_s2, sclk_d;
  logic sdata_s1, sdata_s2;
  logic strobe;

  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;

  logic frame_end, stop_bad, parity_bad, push_req, timeout_hit;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              pop, has_space, wr;

  // Synchronisers idle high so a reset never manufactures a falling edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_s1  <= 1'b1;
      sclk_s2  <= 1'b1;
      sclk_d   <= 1'b1;
      sdata_s1 <= 1'b1;
      sdata_s2 <= 1'b1;
    end else begin
      sclk_s1  <= SCLK;
      sclk_s2  <= sclk_s1;
      sclk_d   <= sclk_s2;
      sdata_s1 <= SDATA;
      sdata_s2 <= sdata_s1;
    end
  end

  assign strobe = sclk_d & ~sclk_s2;

`ifdef SERIAL_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_cnt;

  assign timeout_hit = (state != IDLE) && !strobe && (to_cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RST || state == IDLE || strobe) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    frame_end  = 1'b0;
    stop_bad   = 1'b0;
    parity_bad = 1'b0;
    push_req   = 1'b0;
    case (state)
      IDLE:   if (strobe && !sdata_s2) state_n = DATA;
      DATA:   if (strobe && bit_cnt == LAST_BIT) state_n = PARITY;
      PARITY: if (strobe) state_n = STOP;
      STOP: begin
        if (strobe) begin
          state_n   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout_hit) begin
      state_n = IDLE;
    end
    // Stop-bit error masks any parity verdict on the same frame.
    stop_bad   = frame_end && !sdata_s2;
    parity_bad = frame_end && sdata_s2 && ((^shreg ^ par_bit) != PAR_SENSE);
    push_req   = frame_end && sdata_s2 && !parity_bad;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else if (strobe) begin
      case (state)
        IDLE: bit_cnt <= '0;
        DATA: begin
          shreg   <= {sdata_s2, shreg[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: par_bit <= sdata_s2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      PARITY_ERR <= parity_bad;
      FRAME_ERR  <= stop_bad | timeout_hit;
    end
  end

  // A push into a full FIFO is accepted when a pop frees the head slot on the same edge.
  assign pop       = RD_EN && (count != '0);
  assign has_space = (count != DEPTH_C);
  assign wr        = push_req && (has_space || pop);

  always_ff @(posedge CLK) begin
    if (wr) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !has_space && !pop) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  assign VALID = (count != '0);
  assign FULL  = (count == DEPTH_C);
  assign COUNT = count;
  assign CODE  = VALID ? mem[rd_ptr] : '0;

endmodule

// File: doc/serial_rx_fifo.md
SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, range 5..16.
REQ-002 Parameter FIFO_DEPTH, default 4: received-code buffer entries, power of two, range 2..64.
REQ-003 Parameter PARITY_ODD, default 1: 1 = odd parity, 0 = even parity.
REQ-004 Parameter TIMEOUT_CYC, default 2000: CLK cycles without an SCLK falling edge before a frame is abandoned.
REQ-005 CLK  input  1  sole system clock; all state changes on the rising edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 SCLK  input  1  device serial clock, asynchronous to CLK.
REQ-008 SDATA  input  1  device serial data, asynchronous to CLK.
REQ-009 RD_EN  input  1  pop request; acts only while VALID=1.
REQ-010 CODE  output  DATA_W  FIFO head data, show-ahead; 0 when empty.
REQ-011 VALID  output  1  FIFO non-empty.
REQ-012 FULL  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 COUNT  output  clog2(FIFO_DEPTH+1)  entries held.
REQ-014 PARITY_ERR  output  1  one-cycle pulse, frame discarded on parity mismatch.
REQ-015 FRAME_ERR  output  1  one-cycle pulse, frame discarded on bad stop bit or timeout.
REQ-016 OVERFLOW  output  1  sticky; set when a good frame is dropped because FIFO full.

Function
REQ-017 SCLK and SDATA each pass a 2-flop synchroniser; one further SCLK register gives a falling-edge strobe; SDATA sampled only on the strobe.
REQ-018 Frame: start bit 0, DATA_W data bits LSB first, one parity bit, stop bit 1; DATA_W+3 strobes total.
REQ-019 FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on strobe with SDATA=0; strobe with SDATA=1 in IDLE ignored.
REQ-020 DATA->PARITY after the DATA_W-th data strobe; PARITY->STOP on next strobe; STOP->IDLE on next strobe, always.
REQ-021 Parity check: XOR of data bits and parity bit SHALL equal PARITY_ODD.
REQ-022 At STOP strobe: stop=0 -> FRAME_ERR pulse, discard; else parity bad -> PARITY_ERR pulse, discard; else push data. Stop-bit error takes priority.
REQ-023 Push and error pulses occur on the CLK edge following the stop-bit strobe; VALID/COUNT reflect the push one cycle later.
REQ-024 Pop: RD_EN=1 and VALID=1 advances the read pointer; CODE shows next entry the following cycle; RD_EN while empty ignored.
REQ-025 Push while FULL with no pop: data dropped, OVERFLOW set, COUNT unchanged.
REQ-026 Push and pop same cycle: both occur, COUNT unchanged, including when FULL (no overflow).
REQ-027 Pointers wrap modulo FIFO_DEPTH; order strictly first-in first-out.
REQ-028 Timeout: in any non-IDLE state, counter counts CLK cycles since last strobe; reaching TIMEOUT_CYC returns FSM to IDLE with one FRAME_ERR pulse; counter cleared by every strobe and in IDLE.

Reset
REQ-029 RST=1 at a CLK edge: FSM IDLE, shift register 0, pointers 0, COUNT 0, CODE 0, VALID 0, FULL 0, PARITY_ERR 0, FRAME_ERR 0, OVERFLOW 0, synchronisers 1 (line-idle).
REQ-030 Reset mid-frame discards the partial frame without error pulse; next start bit after reset release is received normally.

Configuration
REQ-031 Macro SERIAL_RX_TIMEOUT_EN defined: timeout counter and REQ-028 behaviour present.
REQ-032 SERIAL_RX_TIMEOUT_EN undefined: no timeout logic; FSM waits indefinitely for strobes; FRAME_ERR only from bad stop bit; TIMEOUT_CYC unused.

Verification
REQ-033 Defaults; frame 0x1C, parity 0, stop 1 -> VALID=1, CODE=0x1C, COUNT=1, no error pulses.
REQ-034 Frame 0x1C, parity 1 -> one PARITY_ERR pulse, COUNT=0; frame 0x1C with stop 0 -> one FRAME_ERR pulse, COUNT=0.
REQ-035 Frames 0x01,0x02,0x03,0x04,0x05 no reads -> FULL=1 after fourth, OVERFLOW=1 after fifth; four RD_EN pops return 0x01..0x04, then VALID=0.
REQ-036 FIFO full, fifth good frame pushed with RD_EN=1 same cycle -> OVERFLOW stays 0, COUNT=4, next CODE=0x02.
REQ-037 With SERIAL_RX_TIMEOUT_EN: start bit + 3 data bits, SCLK held high 2000 cycles -> one FRAME_ERR pulse, FSM IDLE; following frame 0xF0 (parity 1) -> CODE=0xF0.
REQ-038 RST asserted after 5 data bits, released, frame 0xAA (parity 1) sent -> COUNT=1, CODE=0xAA, no error pulses.
